switch_alloc: RTL
=================

# switch_alloc

Per-router switch allocator for the 2x4 mesh NoC. Computes the XY output port for each input's head flit, arbitrates the five output ports among the five input ports, and holds each output for one packet (wormhole) until the tail flit transfers. Sits between the input buffers and the crossbar of each router. Drives crossbar select lines and input-buffer pop grants.

## Interface
Parameters:
- NPORT, 5, number of input and output ports (L, N, E, S, W).
- PW, 3, width of a port index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  allocator enable.
- router_add  in  3  this router's address: [2] = row y, [1:0] = column x.
- req_vld  in  5  input i holds a valid flit.
- req_dst  in  15  destination address of input i's head flit, in bits [3i+2:3i]; sampled only while input i is unlocked.
- req_tail  in  5  input i's current flit is a tail; a single-flit packet has its tail set on the head.
- out_rdy  in  5  output o can accept a flit this cycle.
- gnt  out  5  input i transfers its flit this cycle.
- out_vld  out  5  output o carries a flit this cycle.
- sel  out  15  input index driving output o, in bits [3o+2:3o].

## Operation
- Port codes are L=0, N=1, E=2, S=3, W=4, the same encoding as router_sta.
- XY route, with x = dst[1:0] and y = dst[2]:
  - dst x > own x: E.
  - dst x < own x: W.
  - x equal and dst y > own y: S.
  - x equal and dst y < own y: N.
  - otherwise: L.
- Each output has its own two-state FSM: IDLE and LOCKED(owner). Each output also holds a 3-bit round-robin pointer rr.
- IDLE:
  - Candidates are inputs with req_vld=1, that are not owners of any output, and whose route equals this output.
  - If en=1 and there is at least one candidate, the first candidate searching upward from rr (cyclic over 0..4) wins. The FSM goes to LOCKED(winner) on the next edge.
  - No grant is issued in the IDLE cycle.
- LOCKED(k):
  - gnt[k] = out_vld[o] = req_vld[k] & out_rdy[o] & en.
  - A transfer with req_tail[k]=1 returns the FSM to IDLE and sets rr to (k+1) mod 5.
- An input owns at most one output at a time. The route is ignored for owned inputs, because body flits carry no destination.
- Distinct outputs allocate independently in the same cycle.
- sel[o] = owner while LOCKED, and 0 while IDLE.
- gnt is one-hot per input by construction.
- en=0: no new locks and all grants are 0. Existing locks are held, and rr does not change.

## Timing
- Reset values: all FSMs IDLE, rr=0, gnt=0, out_vld=0, sel=0.
- Reset asserted mid-packet drops all locks immediately (asynchronously). The upstream buffers are flushed by the same reset.
- Lock latency: a request present in cycle N gets its first grant in cycle N+1, provided out_rdy=1.
- Grant and out_vld are combinational from the registered lock state and the current req_vld and out_rdy. There is no registered output stage.
- out_rdy=0 while LOCKED stalls the packet. The lock is held indefinitely, with no timeout.
- A tail transfer in cycle N means the output can re-lock at edge N+1 and grant a new packet in cycle N+2. One idle cycle between packets on the same output is required.
- A request whose route is the output it arrived on (U-turn) is legal and is allocated normally.

## Configuration
- SA_FIXED_PRIO_EN:
  - Defined: IDLE arbitration is fixed priority, lowest input index wins, and rr is not implemented.
  - Undefined (default): round-robin as specified above.

## Test plan
- Routing: router_add=3'b000, a single input L requests each dst 000..111 in turn, with single-flit packets and all out_rdy=1.
  - Dst 001, 010, 011 and 101 grant on E.
  - Dst 100 grants on S.
  - Dst 000 grants on L.
  - Each grant comes one cycle after the request.
- Wormhole hold: input N sends 3 flits to dst E, tail on flit 3. Input W requests E from cycle 1.
  - W is held off until one cycle after N's tail transfers.
  - sel for E reads 1, then 4.
- Round-robin: inputs L, N, S all request E continuously with single-flit packets.
  - Grant order is L, N, S, L, ...
  - Each grant is separated by one idle cycle.
  - With SA_FIXED_PRIO_EN defined, L wins every time.
- Back-pressure and enable:
  - Locked output with out_rdy=0 for 4 cycles: gnt=0 for all 4 cycles, the lock is kept, and flits resume when out_rdy=1.
  - en=0: no new locks form.
- Parallel and reset: L→E and W→L packets run concurrently with grants in the same cycle. rst_n pulsed mid-packet gives all outputs 0 and the FSMs IDLE immediately.

Source files
------------

// File: rtl/switch_alloc.sv
// Wormhole switch allocator: XY route per input, per-output lock FSM with round-robin arbitration.
// Build option: define SA_FIXED_PRIO_EN for fixed lowest-index priority (no rr pointers).
module switch_alloc #(
   parameter int unsigned NPORT = 5,
   parameter int unsigned PW    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [2:0]            router_add,
   input  logic [NPORT-1:0]      req_vld,
   input  logic [NPORT*PW-1:0]   req_dst,
   input  logic [NPORT-1:0]      req_tail,
   input  logic [NPORT-1:0]      out_rdy,
   output logic [NPORT-1:0]      gnt,
   output logic [NPORT-1:0]      out_vld,
   output logic [NPORT*PW-1:0]   sel
);

   localparam int unsigned SW = PW + 1;
   localparam logic [PW-1:0] P_L = PW'(0);
   localparam logic [PW-1:0] P_N = PW'(1);
   localparam logic [PW-1:0] P_E = PW'(2);
   localparam logic [PW-1:0] P_S = PW'(3);
   localparam logic [PW-1:0] P_W = PW'(4);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t            state [NPORT];
   logic [PW-1:0]     owner [NPORT];
`ifndef SA_FIXED_PRIO_EN
   logic [PW-1:0]     rr    [NPORT];
`endif
   logic [PW-1:0]     route [NPORT];
   logic [NPORT-1:0]  cand  [NPORT];
   logic [NPORT-1:0]  owned;
   logic [NPORT-1:0]  found;
   logic [PW-1:0]     win   [NPORT];
   logic [NPORT-1:0]  tail_xfer;

   // XY routing of each input's head destination
   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         route[i] = P_L;
         if (req_dst[i*PW +: 2] > router_add[1:0])
            route[i] = P_E;
         else if (req_dst[i*PW +: 2] < router_add[1:0])
            route[i] = P_W;
         else if (req_dst[i*PW+2] && !router_add[2])
            route[i] = P_S;
         else if (!req_dst[i*PW+2] && router_add[2])
            route[i] = P_N;
      end
   end

   always_comb begin
      owned = '0;
      for (int o = 0; o < NPORT; o++)
         for (int i = 0; i < NPORT; i++)
            if (state[o] == ST_LOCKED && owner[o] == PW'(i))
               owned[i] = 1'b1;
   end

   always_comb begin
      for (int o = 0; o < NPORT; o++)
         for (int i = 0; i < NPORT; i++)
            cand[o][i] = req_vld[i] && !owned[i] && (route[i] == PW'(o));
   end

   // Pick the winner for each idle output
   always_comb begin
      logic [SW-1:0] idx;
      idx   = '0;
      found = '0;
      for (int o = 0; o < NPORT; o++) begin
         win[o] = '0;
`ifdef SA_FIXED_PRIO_EN
         for (int k = NPORT-1; k >= 0; k--) begin
            if (cand[o][k]) begin
               found[o] = 1'b1;
               win[o]   = PW'(k);
            end
         end
`else
         for (int k = 0; k < NPORT; k++) begin
            idx = SW'(rr[o]) + SW'(k);
            if (idx >= SW'(NPORT))
               idx = idx - SW'(NPORT);
            if (!found[o] && cand[o][idx[PW-1:0]]) begin
               found[o] = 1'b1;
               win[o]   = idx[PW-1:0];
            end
         end
`endif
      end
   end

   // Grants and crossbar selects straight from the lock state
   always_comb begin
      gnt       = '0;
      out_vld   = '0;
      sel       = '0;
      tail_xfer = '0;
      for (int o = 0; o < NPORT; o++) begin
         if (state[o] == ST_LOCKED) begin
            sel[o*PW +: PW] = owner[o];
            for (int i = 0; i < NPORT; i++) begin
               if (owner[o] == PW'(i) && req_vld[i] && out_rdy[o] && en) begin
                  gnt[i]       = 1'b1;
                  out_vld[o]   = 1'b1;
                  tail_xfer[o] = req_tail[i];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < NPORT; o++) begin
            state[o] <= ST_IDLE;
            owner[o] <= '0;
`ifndef SA_FIXED_PRIO_EN
            rr[o]    <= '0;
`endif
         end
      end else begin
         for (int o = 0; o < NPORT; o++) begin
            case (state[o])
               ST_IDLE: begin
                  if (en && found[o]) begin
                     state[o] <= ST_LOCKED;
                     owner[o] <= win[o];
                  end
               end
               ST_LOCKED: begin
                  if (tail_xfer[o]) begin
                     state[o] <= ST_IDLE;
`ifndef SA_FIXED_PRIO_EN
                     rr[o]    <= (owner[o] == PW'(NPORT-1)) ? '0 : owner[o] + PW'(1);
`endif
                  end
               end
               default: state[o] <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
